sample_scaler_pipe: RTL and testbench



---
 rtl/sample_scale_pkg.sv | 24 ++
 rtl/sample_scaler_pipe_scale_core.sv | 48 ++++
 rtl/sample_scaler_pipe.sv | 169 ++++++++++++++++
 tb/tb_sample_scaler_pipe.sv | 519 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_scale_pkg.sv
// sample_scale_pkg: shared sizing helpers and the per-channel
// gain/overflow configuration record for sample_scaler_pipe.
`timescale 1ns/1ps
package sample_scale_pkg;

    // Widest scale code the config record can carry.
    localparam int SCALE_W_MAX = 8;

    typedef struct packed {
        logic [SCALE_W_MAX-1:0] scale;
        logic                   saturate;
    } scale_cfg_t;

    // Zero code of an offset-binary sample, e.g. 127 for 8 bits.
    function automatic int mid_code(input int sample_w);
        return (1 << (sample_w - 1)) - 1;
    endfunction

    // Width that holds (d <<< bias) + midpoint without truncation.
    function automatic int full_w(input int sample_w, input int bias);
        return sample_w + 2 + bias;
    endfunction

endpackage

// File: rtl/sample_scaler_pipe_scale_core.sv
// scale_core: combinational power-of-two gain about the mid-code,
// with clamp or wrap of results that leave the sample range.
`timescale 1ns/1ps
module scale_core
    import sample_scale_pkg::*;
#(
    parameter int SAMPLE_W  = 8,
    parameter int GAIN_BIAS = 4,
    parameter int MIDPOINT  = mid_code(SAMPLE_W)
) (
    input  logic signed [SAMPLE_W:0]   i_d,
    input  scale_cfg_t                 i_cfg,
    output logic        [SAMPLE_W-1:0] o_sample,
    output logic                       o_in_range
);

    localparam int FW = full_w(SAMPLE_W, GAIN_BIAS);
    localparam logic signed [FW-1:0] LP_MID = FW'(MIDPOINT);

    logic signed [FW-1:0] w_dx;
    logic signed [FW-1:0] w_p;
    logic signed [FW-1:0] w_r;
    logic                 w_neg;
    logic                 w_over;

    assign w_dx = {{(FW - SAMPLE_W - 1){i_d[SAMPLE_W]}}, i_d};

    // Arithmetic right shift floors toward minus infinity.
    assign w_p = (w_dx <<< GAIN_BIAS) >>> i_cfg.scale;
    assign w_r = w_p + LP_MID;

    assign w_neg      = w_r[FW-1];
    assign w_over     = !w_neg && (w_r[FW-2:SAMPLE_W] != '0);
    assign o_in_range = !w_neg && !w_over;

    // Clamp to the rails or keep the low bits (modulo wrap).
    always_comb begin
        o_sample = w_r[SAMPLE_W-1:0];
        if (i_cfg.saturate) begin
            if (w_neg) begin
                o_sample = '0;
            end else if (w_over) begin
                o_sample = '1;
            end
        end
    end

endmodule

// File: rtl/sample_scaler_pipe.sv
// sample_scaler_pipe: two-stage multi-channel sample scaler with
// valid/ready handshakes and per-channel out-of-range counters.
`timescale 1ns/1ps
module sample_scaler_pipe
    import sample_scale_pkg::*;
#(
    parameter int SAMPLE_W  = 8,
    parameter int CHANNELS  = 2,
    parameter int CH_W      = 1,
    parameter int SCALE_W   = 3,
    parameter int GAIN_BIAS = 4,
    parameter int MIDPOINT  = mid_code(SAMPLE_W),
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_sample,
    input  logic [CH_W-1:0]     in_ch,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [SCALE_W-1:0]  cfg_scale,
    input  logic                cfg_saturate,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_sample,
    output logic [CH_W-1:0]     out_ch,
    output logic                out_in_range,
    input  logic [CH_W-1:0]     cnt_sel,
    output logic [CNT_W-1:0]    cnt_value,
    input  logic                cnt_clear
);

    localparam logic [SAMPLE_W:0] LP_MID = (SAMPLE_W + 1)'(MIDPOINT);
    localparam logic [CH_W:0]     LP_NCH = (CH_W + 1)'(CHANNELS);
    localparam scale_cfg_t LP_CFG_RST = '{
        scale:    SCALE_W_MAX'(GAIN_BIAS),
        saturate: 1'b1
    };

    scale_cfg_t r_cfg [CHANNELS];

    logic                       r_a_valid;
    logic signed [SAMPLE_W:0]   r_a_d;
    scale_cfg_t                 r_a_cfg;
    logic        [CH_W-1:0]     r_a_ch;

    logic                       r_b_valid;
    logic        [SAMPLE_W-1:0] r_b_sample;
    logic        [CH_W-1:0]     r_b_ch;
    logic                       r_b_in_range;

    logic        [CNT_W-1:0]    r_cnt [CHANNELS];

    logic                       w_b_adv;
    logic                       w_a_adv;
    logic                       w_xfer;
    logic                       w_in_known;
    logic                       w_cfg_known;
    logic                       w_sel_known;
    logic signed [SAMPLE_W:0]   w_d;
    scale_cfg_t                 w_in_cfg;
    scale_cfg_t                 w_cfg_wr;
    logic        [SAMPLE_W-1:0] w_core_sample;
    logic                       w_core_in_range;

    assign w_b_adv  = !r_b_valid || out_ready;
    assign w_a_adv  = !r_a_valid || w_b_adv;
    assign in_ready = w_a_adv;
    assign w_xfer   = r_b_valid && out_ready;

    assign w_in_known  = ({1'b0, in_ch} < LP_NCH);
    assign w_cfg_known = ({1'b0, cfg_ch} < LP_NCH);
    assign w_sel_known = ({1'b0, cnt_sel} < LP_NCH);

    assign w_d = $signed({1'b0, in_sample} - LP_MID);

    // Unknown channels fall back to unity gain with clamping.
    assign w_in_cfg = w_in_known ? r_cfg[in_ch] : LP_CFG_RST;

    assign w_cfg_wr = '{
        scale:    SCALE_W_MAX'(cfg_scale),
        saturate: cfg_saturate
    };

    // Per-channel config file; a sample reads the pre-write value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_cfg[i] <= LP_CFG_RST;
            end
        end else if (cfg_we && w_cfg_known) begin
            r_cfg[cfg_ch] <= w_cfg_wr;
        end
    end

    // Stage A: centred sample plus the config captured on accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_valid <= 1'b0;
            r_a_d     <= '0;
            r_a_cfg   <= LP_CFG_RST;
            r_a_ch    <= '0;
        end else if (w_a_adv) begin
            r_a_valid <= in_valid;
            if (in_valid) begin
                r_a_d   <= w_d;
                r_a_cfg <= w_in_cfg;
                r_a_ch  <= in_ch;
            end
        end
    end

    scale_core #(
        .SAMPLE_W  (SAMPLE_W),
        .GAIN_BIAS (GAIN_BIAS),
        .MIDPOINT  (MIDPOINT)
    ) u_core (
        .i_d        (r_a_d),
        .i_cfg      (r_a_cfg),
        .o_sample   (w_core_sample),
        .o_in_range (w_core_in_range)
    );

    // Stage B: output registers, frozen while downstream stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_b_valid    <= 1'b0;
            r_b_sample   <= '0;
            r_b_ch       <= '0;
            r_b_in_range <= 1'b1;
        end else if (w_b_adv) begin
            r_b_valid <= r_a_valid;
            if (r_a_valid) begin
                r_b_sample   <= w_core_sample;
                r_b_ch       <= r_a_ch;
                r_b_in_range <= w_core_in_range;
            end
        end
    end

    assign out_valid    = r_b_valid;
    assign out_sample   = r_b_sample;
    assign out_ch       = r_b_ch;
    assign out_in_range = r_b_in_range;

    // Saturating out-of-range counters; clear wins over increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (cnt_clear) begin
                    r_cnt[i] <= '0;
                end else if (w_xfer && !r_b_in_range &&
                             (r_b_ch == CH_W'(i)) &&
                             (r_cnt[i] != '1)) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign cnt_value = w_sel_known ? r_cnt[cnt_sel] : '0;

endmodule

// File: tb/tb_sample_scaler_pipe.sv
// tb_sample_scaler_pipe: directed and randomized-stall checks of
// sample_scaler_pipe with hand-computed expected values.
`timescale 1ns/1ps
module tb_sample_scaler_pipe;

    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [7:0]      in_sample = '0;
    logic [0:0]      in_ch = '0;
    logic            cfg_we = 1'b0;
    logic [0:0]      cfg_ch = '0;
    logic [2:0]      cfg_scale = '0;
    logic            cfg_saturate = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [7:0]      out_sample;
    logic [0:0]      out_ch;
    logic            out_in_range;
    logic [0:0]      cnt_sel = '0;
    logic [CNTW-1:0] cnt_value;
    logic            cnt_clear = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sample_scaler_pipe #(
        .CNT_W (CNTW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sample    (in_sample),
        .in_ch        (in_ch),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_scale    (cfg_scale),
        .cfg_saturate (cfg_saturate),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sample   (out_sample),
        .out_ch       (out_ch),
        .out_in_range (out_in_range),
        .cnt_sel      (cnt_sel),
        .cnt_value    (cnt_value),
        .cnt_clear    (cnt_clear)
    );

    // Present one sample for one cycle (called at a negedge).
    task automatic put(input logic [7:0] s, input logic [0:0] ch);
        in_valid  = 1'b1;
        in_sample = s;
        in_ch     = ch;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic set_cfg(input logic [0:0] ch, input logic [2:0] sc,
                           input logic sat);
        cfg_we       = 1'b1;
        cfg_ch       = ch;
        cfg_scale    = sc;
        cfg_saturate = sat;
        @(negedge clk);
        cfg_we       = 1'b0;
    endtask

    // Reference: floor((s-127)*16 / 2^sc) + 127, then clamp or wrap.
    function automatic int model(input int s, input int sc, input bit sat,
                                 output bit inr);
        int num, den, q, r;
        num = (s - 127) * 16;
        den = 1 << sc;
        q   = num / den;
        if (num < 0 && (num % den) != 0) q = q - 1;
        r   = q + 127;
        inr = (r >= 0) && (r <= 255);
        if (inr) return r;
        if (sat) return (r < 0) ? 0 : 255;
        return r & 255;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid: got %0b expected 0", out_valid);
        end
        checks++;
        if (out_sample !== 8'd0) begin
            errors++;
            $display("FAIL rst_sample: got %0d expected 0", out_sample);
        end
        checks++;
        if (out_ch !== 1'b0) begin
            errors++;
            $display("FAIL rst_ch: got %0d expected 0", out_ch);
        end
        checks++;
        if (out_in_range !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_range: got %0b expected 1", out_in_range);
        end
        checks++;
        if (cnt_value !== 4'd0) begin
            errors++;
            $display("FAIL rst_cnt: got %0d expected 0", cnt_value);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_ready: got %0b expected 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_unity();
        logic [7:0] v [3];
        v[0] = 8'd0;
        v[1] = 8'd127;
        v[2] = 8'd255;
        for (int i = 0; i < 3; i++) begin
            put(v[i], 1'b0);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL unity_latency[%0d]: got %0b expected 0",
                         i, out_valid);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL unity_valid[%0d]: got %0b expected 1",
                         i, out_valid);
            end
            checks++;
            if (out_sample !== v[i]) begin
                errors++;
                $display("FAIL unity_sample[%0d]: got %0d expected %0d",
                         i, out_sample, v[i]);
            end
            checks++;
            if (out_in_range !== 1'b1) begin
                errors++;
                $display("FAIL unity_range[%0d]: got %0b expected 1",
                         i, out_in_range);
            end
        end
    endtask

    task automatic test_scale3();
        set_cfg(1'b0, 3'd3, 1'b1);
        put(8'd200, 1'b0);
        @(negedge clk);
        checks++;
        if (out_sample !== 8'd255 || out_in_range !== 1'b0) begin
            errors++;
            $display("FAIL s3_sat: got %0d/%0b expected 255/0",
                     out_sample, out_in_range);
        end
        @(negedge clk);
        cnt_sel = 1'b0;
        #1;
        checks++;
        if (cnt_value !== 4'd1) begin
            errors++;
            $display("FAIL s3_sat_cnt: got %0d expected 1", cnt_value);
        end
        @(negedge clk);
        set_cfg(1'b0, 3'd3, 1'b0);
        put(8'd200, 1'b0);
        @(negedge clk);
        checks++;
        if (out_sample !== 8'd17 || out_in_range !== 1'b0) begin
            errors++;
            $display("FAIL s3_wrap: got %0d/%0b expected 17/0",
                     out_sample, out_in_range);
        end
        @(negedge clk);
        checks++;
        if (cnt_value !== 4'd2) begin
            errors++;
            $display("FAIL s3_wrap_cnt: got %0d expected 2", cnt_value);
        end
    endtask

    task automatic test_scale5_7();
        set_cfg(1'b0, 3'd5, 1'b1);
        put(8'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (out_sample !== 8'd63 || out_in_range !== 1'b1) begin
            errors++;
            $display("FAIL s5_zero: got %0d/%0b expected 63/1",
                     out_sample, out_in_range);
        end
        put(8'd255, 1'b0);
        @(negedge clk);
        checks++;
        if (out_sample !== 8'd191 || out_in_range !== 1'b1) begin
            errors++;
            $display("FAIL s5_full: got %0d/%0b expected 191/1",
                     out_sample, out_in_range);
        end
        set_cfg(1'b0, 3'd7, 1'b1);
        put(8'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (out_sample !== 8'd111 || out_in_range !== 1'b1) begin
            errors++;
            $display("FAIL s7_zero: got %0d/%0b expected 111/1",
                     out_sample, out_in_range);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] s [5];
        logic [0:0] c [5];
        logic [7:0] e [5];
        logic       r [5];
        s = '{8'd0, 8'd200, 8'd255, 8'd200, 8'd200};
        c = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        e = '{8'd63, 8'd200, 8'd191, 8'd200, 8'd255};
        r = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        set_cfg(1'b0, 3'd5, 1'b1);
        set_cfg(1'b1, 3'd4, 1'b1);
        for (int i = 0; i < 7; i++) begin
            if (i < 5) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready[%0d]: got %0b expected 1",
                             i, in_ready);
                end
            end
            if (i >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_sample !== e[i-2] ||
                    out_ch !== c[i-2] || out_in_range !== r[i-2]) begin
                    errors++;
                    $display("FAIL b2b_out[%0d]: got v%0b %0d ch%0d r%0b expected v1 %0d ch%0d r%0b",
                             i - 2, out_valid, out_sample, out_ch,
                             out_in_range, e[i-2], c[i-2], r[i-2]);
                end
            end
            in_valid     = (i < 5);
            in_sample    = (i < 5) ? s[i] : 8'd0;
            in_ch        = (i < 5) ? c[i] : 1'b0;
            cfg_we       = (i == 3);
            cfg_ch       = 1'b1;
            cfg_scale    = 3'd3;
            cfg_saturate = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        cnt_sel  = 1'b1;
        #1;
        checks++;
        if (cnt_value !== 4'd1) begin
            errors++;
            $display("FAIL b2b_cnt1: got %0d expected 1", cnt_value);
        end
        cnt_sel = 1'b0;
        #1;
        checks++;
        if (cnt_value !== 4'd2) begin
            errors++;
            $display("FAIL b2b_cnt0: got %0d expected 2", cnt_value);
        end
        @(negedge clk);
    endtask

    task automatic test_random_stall();
        int  sent = 0;
        int  got = 0;
        int  cyc = 0;
        bit  acc_pend = 1'b0;
        int  qs [$];
        int  qc [$];
        bit  qr [$];
        int  cm [2];
        bit  held = 1'b0;
        int  hs = 0;
        int  hc = 0;
        bit  hr = 1'b0;
        bit  inr;
        int  ev;
        int  es, ec;
        bit  er;
        cm[0] = 0;
        cm[1] = 0;
        set_cfg(1'b0, 3'd3, 1'b0);
        set_cfg(1'b1, 3'd2, 1'b1);
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        while (got < 1000 && cyc < 20000) begin
            if (acc_pend) begin
                in_valid = 1'b0;
                acc_pend = 1'b0;
            end
            if (!in_valid && sent < 1000) begin
                in_valid  = 1'b1;
                in_sample = 8'($urandom_range(0, 255));
                in_ch     = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || int'(out_sample) != hs ||
                    int'(out_ch) != hc || out_in_range !== hr) begin
                    errors++;
                    $display("FAIL stall_hold: got v%0b %0d ch%0d r%0b expected v1 %0d ch%0d r%0b",
                             out_valid, out_sample, out_ch, out_in_range,
                             hs, hc, hr);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (qs.size() == 0) begin
                    errors++;
                    $display("FAIL stream_dup: got extra output %0d expected none",
                             out_sample);
                end else begin
                    es = qs.pop_front();
                    ec = qc.pop_front();
                    er = qr.pop_front();
                    if (int'(out_sample) != es || int'(out_ch) != ec ||
                        out_in_range !== er) begin
                        errors++;
                        $display("FAIL stream_out[%0d]: got %0d ch%0d r%0b expected %0d ch%0d r%0b",
                                 got, out_sample, out_ch, out_in_range,
                                 es, ec, er);
                    end
                    if (!er && cm[ec] < 15) cm[ec]++;
                end
                got++;
            end
            if (in_valid && in_ready) begin
                ev = model(int'(in_sample), in_ch ? 2 : 3, in_ch, inr);
                qs.push_back(ev);
                qc.push_back(int'(in_ch));
                qr.push_back(inr);
                sent++;
                acc_pend = 1'b1;
            end
            held = out_valid && !out_ready;
            hs   = int'(out_sample);
            hc   = int'(out_ch);
            hr   = out_in_range;
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 1000) begin
            errors++;
            $display("FAIL stream_count: got %0d expected 1000", got);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || qs.size() != 0) begin
            errors++;
            $display("FAIL stream_drain: got v%0b left %0d expected v0 left 0",
                     out_valid, qs.size());
        end
        for (int ch = 0; ch < 2; ch++) begin
            cnt_sel = 1'(ch);
            #1;
            checks++;
            if (int'(cnt_value) != cm[ch]) begin
                errors++;
                $display("FAIL stream_cnt[%0d]: got %0d expected %0d",
                         ch, cnt_value, cm[ch]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_counter_clear();
        cnt_sel = 1'b0;
        #1;
        checks++;
        if (cnt_value !== 4'd15) begin
            errors++;
            $display("FAIL cnt_saturate: got %0d expected 15", cnt_value);
        end
        @(negedge clk);
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        checks++;
        if (cnt_value !== 4'd0) begin
            errors++;
            $display("FAIL cnt_clear: got %0d expected 0", cnt_value);
        end
        set_cfg(1'b0, 3'd3, 1'b1);
        put(8'd200, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (cnt_value !== 4'd1) begin
            errors++;
            $display("FAIL cnt_inc: got %0d expected 1", cnt_value);
        end
        put(8'd200, 1'b0);
        @(negedge clk);
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        checks++;
        if (cnt_value !== 4'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL cnt_clear_coincident: got %0d v%0b expected 0 v0",
                     cnt_value, out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        set_cfg(1'b1, 3'd6, 1'b0);
        put(8'd200, 1'b0);
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sample = 8'd200;
        in_ch     = 1'b0;
        @(negedge clk);
        in_sample = 8'd100;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || cnt_value !== 4'd1) begin
            errors++;
            $display("FAIL pre_reset: got v%0b cnt %0d expected v1 cnt 1",
                     out_valid, cnt_value);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sample !== 8'd0 ||
            out_ch !== 1'b0 || out_in_range !== 1'b1 ||
            cnt_value !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset: got v%0b %0d ch%0d r%0b cnt %0d expected v0 0 ch0 r1 cnt 0",
                     out_valid, out_sample, out_ch, out_in_range, cnt_value);
        end
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got rdy%0b v%0b expected rdy1 v0",
                     in_ready, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_empty: got %0b expected 0", out_valid);
        end
        put(8'd200, 1'b0);
        @(negedge clk);
        checks++;
        if (out_sample !== 8'd200 || out_in_range !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_cfg0: got %0d/%0b expected 200/1",
                     out_sample, out_in_range);
        end
        put(8'd0, 1'b1);
        @(negedge clk);
        checks++;
        if (out_sample !== 8'd0 || out_ch !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_cfg1: got %0d ch%0d expected 0 ch1",
                     out_sample, out_ch);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_unity();
        test_scale3();
        test_scale5_7();
        test_back_to_back();
        test_random_stall();
        test_counter_clear();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
